// File: rtl/e203_icb_mem_rsp_pkg.sv
// Shared constants, the response entry layout and the byte-merge helper
// for the ICB memory responder.
package e203_icb_mem_rsp_pkg;

    localparam int                ICB_AW    = 32;
    localparam int                ICB_DW    = 32;
    localparam int                ICB_MW    = ICB_DW / 8;
    localparam int                MEM_DEPTH = 1024;
    localparam logic [ICB_AW-1:0] MEM_BASE  = 32'h8000_0000;
    localparam int                RSP_OUTS  = 2;

    // One queued response: error flag plus read data.
    typedef struct packed {
        logic              err;
        logic [ICB_DW-1:0] rdata;
    } rsp_entry_t;

    // Replace the bytes of old_word selected by mask with the bytes of new_word.
    function automatic logic [ICB_DW-1:0] merge_bytes(
        input logic [ICB_DW-1:0] old_word,
        input logic [ICB_DW-1:0] new_word,
        input logic [ICB_MW-1:0] mask
    );
        logic [ICB_DW-1:0] res;
        res = old_word;
        for (int b = 0; b < ICB_MW; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/e203_icb_mem_rsp_fifo.sv
// In-order response queue. Pointers carry one extra wrap bit so that
// empty is a plain pointer compare; storage is rounded up to a power of 2.
module e203_icb_mem_rsp_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         empty
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NENT = 1 << PW;

    logic [W-1:0] ent_r [NENT];
    logic [PW:0]  wptr_r;
    logic [PW:0]  rptr_r;

    // Pointer advance; wrap happens by natural overflow of the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= {(PW+1){1'b0}};
            rptr_r <= {(PW+1){1'b0}};
        end else begin
            if (push) begin
                wptr_r <= wptr_r + (PW+1)'(1);
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop) begin
                rptr_r <= rptr_r + (PW+1)'(1);
            end else begin
                rptr_r <= rptr_r;
            end
        end
    end

    // Entry storage; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_r[wptr_r[PW-1:0]] <= push_data;
        end
    end

    // Head entry and empty flag, both straight from flops.
    always_comb begin
        pop_data = ent_r[rptr_r[PW-1:0]];
        empty    = (wptr_r == rptr_r);
    end

endmodule

// File: rtl/e203_icb_mem_rsp.sv
// ICB target backed by a local word-addressed memory. Every accepted command
// produces exactly one in-order response; out-of-range or misaligned accesses
// answer with err=1 and leave memory untouched.
module e203_icb_mem_rsp
    import e203_icb_mem_rsp_pkg::*;
#(
    parameter int            AW         = ICB_AW,
    parameter int            DW         = ICB_DW,
    parameter int            DEPTH      = MEM_DEPTH,
    parameter logic [AW-1:0] BASE_ADDR  = MEM_BASE,
    parameter int            OUTS_DEPTH = RSP_OUTS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            icb_cmd_valid,
    output logic            icb_cmd_ready,
    input  logic [AW-1:0]   icb_cmd_addr,
    input  logic            icb_cmd_read,
    input  logic [DW-1:0]   icb_cmd_wdata,
    input  logic [DW/8-1:0] icb_cmd_wmask,
    output logic            icb_rsp_valid,
    input  logic            icb_rsp_ready,
    output logic            icb_rsp_err,
    output logic [DW-1:0]   icb_rsp_rdata
);

    localparam int IDXW = $clog2(DEPTH);
    localparam int CW   = $clog2(OUTS_DEPTH + 1);

    logic [DW-1:0]   mem_r [DEPTH];
    logic [CW-1:0]   cnt_r;
    logic            cmd_hsk_s;
    logic            rsp_hsk_s;
    logic [AW-1:0]   off_s;
    logic            in_range_s;
    logic [IDXW-1:0] idx_s;
    rsp_entry_t      push_s;
    rsp_entry_t      head_s;
    logic            fifo_empty_s;

    // Handshakes and address decode; alignment is checked on the offset,
    // which equals addr[1:0] because the base is word aligned.
    always_comb begin
        cmd_hsk_s  = icb_cmd_valid & icb_cmd_ready;
        rsp_hsk_s  = icb_rsp_valid & icb_rsp_ready;
        off_s      = icb_cmd_addr - BASE_ADDR;
        in_range_s = (off_s[AW-1:IDXW+2] == '0) && (off_s[1:0] == 2'b00);
        idx_s      = off_s[IDXW+1:2];
    end

    // Build the response at command acceptance; reads capture the word now,
    // so later writes cannot disturb a queued response.
    always_comb begin
        push_s.err   = 1'b1;
        push_s.rdata = {DW{1'b0}};
        if (in_range_s && icb_cmd_read) begin
            push_s.err   = 1'b0;
            push_s.rdata = mem_r[idx_s];
        end else if (in_range_s) begin
            push_s.err   = 1'b0;
            push_s.rdata = {DW{1'b0}};
        end else begin
            push_s.err   = 1'b1;
            push_s.rdata = {DW{1'b0}};
        end
    end

    // Byte-masked memory write on an accepted in-range write; memory is not reset.
    always_ff @(posedge clk) begin
        if (cmd_hsk_s && in_range_s && !icb_cmd_read) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], icb_cmd_wdata, icb_cmd_wmask);
        end
    end

    // Outstanding command count: up on accept, down on response, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            case ({cmd_hsk_s, rsp_hsk_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    e203_icb_mem_rsp_fifo #(
        .W     ($bits(rsp_entry_t)),
        .DEPTH (OUTS_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_hsk_s),
        .push_data (push_s),
        .pop       (rsp_hsk_s),
        .pop_data  (head_s),
        .empty     (fifo_empty_s)
    );

    // Outputs depend only on flops: cmd_ready from the count, response from the queue head.
    always_comb begin
        icb_cmd_ready = (cnt_r != CW'(OUTS_DEPTH));
        icb_rsp_valid = !fifo_empty_s;
        if (fifo_empty_s) begin
            icb_rsp_err   = 1'b0;
            icb_rsp_rdata = {DW{1'b0}};
        end else begin
            icb_rsp_err   = head_s.err;
            icb_rsp_rdata = head_s.rdata;
        end
    end

endmodule

// File: tb/tb_e203_icb_mem_rsp.sv
// Randomised and directed bench for e203_icb_mem_rsp against a queue/array
// reference model of the ICB responder.
module tb_e203_icb_mem_rsp;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          OUTS  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          icb_cmd_valid;
    logic          icb_cmd_ready;
    logic [AW-1:0] icb_cmd_addr;
    logic          icb_cmd_read;
    logic [DW-1:0] icb_cmd_wdata;
    logic [3:0]    icb_cmd_wmask;
    logic          icb_rsp_valid;
    logic          icb_rsp_ready;
    logic          icb_rsp_err;
    logic [DW-1:0] icb_rsp_rdata;

    e203_icb_mem_rsp #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .OUTS_DEPTH(OUTS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_err   (icb_rsp_err),
        .icb_rsp_rdata (icb_rsp_rdata)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mdl_mem [int];
    logic [32:0] exp_q [$];
    int          words [8] = '{0, 4, 1, 2, 7, 100, 511, DEPTH-1};

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        last_cmd_hsk;
    logic        last_rsp_hsk;
    logic        last_err;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] waddr(input int w);
        return BASE + 32'(w) * 32'd4;
    endfunction

    // One clock cycle: check DUT against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic [32:0] e;
        logic [31:0] off;
        logic        inr;
        int          w;
        logic [31:0] nw;
        @(negedge clk);
        cyc++;
        check("cmd_ready", icb_cmd_ready, exp_q.size() < OUTS);
        check("rsp_valid", icb_rsp_valid, exp_q.size() != 0);
        last_cmd_hsk = icb_cmd_valid && icb_cmd_ready;
        last_rsp_hsk = icb_rsp_valid && icb_rsp_ready;
        if (exp_q.size() != 0 && icb_rsp_valid) begin
            e = exp_q[0];
            check("rsp_err", icb_rsp_err, e[32]);
            check("rsp_rdata", icb_rsp_rdata, e[31:0]);
            if (last_rsp_hsk) begin
                last_err   = icb_rsp_err;
                last_rdata = icb_rsp_rdata;
                void'(exp_q.pop_front());
            end
        end
        if (last_cmd_hsk) begin
            off = icb_cmd_addr - BASE;
            inr = (off < 32'(DEPTH * 4)) && (off % 4 == 0);
            w   = int'(off / 4);
            if (!inr) begin
                exp_q.push_back({1'b1, 32'h0});
            end else if (icb_cmd_read) begin
                exp_q.push_back({1'b0, mdl_mem[w]});
            end else begin
                exp_q.push_back({1'b0, 32'h0});
                nw = mdl_mem.exists(w) ? mdl_mem[w] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (icb_cmd_wmask[b]) nw[8*b +: 8] = icb_cmd_wdata[8*b +: 8];
                end
                mdl_mem[w] = nw;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = a;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (last_cmd_hsk) break;
        end
        check("issue_accept", last_cmd_hsk, 1'b1);
        icb_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        icb_rsp_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle();
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic rand_cmd();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      icb_cmd_addr = BASE + 32'(DEPTH * 4);
        else if (r == 1) icb_cmd_addr = BASE + 32'h2;
        else             icb_cmd_addr = waddr(words[$urandom_range(0, 7)]);
        icb_cmd_read  = 1'($urandom_range(0, 1));
        icb_cmd_wdata = $urandom;
        icb_cmd_wmask = 4'($urandom_range(0, 15));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int accepted;
        int first_rsp;
        int third_acc;
        rst_n = 1'b0; icb_cmd_valid = 1'b0; icb_cmd_addr = 32'h0; icb_cmd_read = 1'b0;
        icb_cmd_wdata = 32'h0; icb_cmd_wmask = 4'h0; icb_rsp_ready = 1'b1;
        last_cmd_hsk = 1'b0; last_rsp_hsk = 1'b0; last_err = 1'b0; last_rdata = 32'h0;
        #12;
        check("rst_cmd_ready", icb_cmd_ready, 1'b1);
        check("rst_rsp_valid", icb_rsp_valid, 1'b0);
        check("rst_rsp_err", icb_rsp_err, 1'b0);
        check("rst_rsp_rdata", icb_rsp_rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();

        // Test 1: write then read back
        issue(1'b0, BASE + 32'h10, 32'hDEADBEEF, 4'hF);
        issue(1'b1, BASE + 32'h10, 32'h0, 4'h0);
        drain();
        check("t1_rdata", last_rdata, 32'hDEADBEEF);
        check("t1_err", last_err, 1'b0);

        // Initialise every word the random phases may read
        for (int i = 0; i < 8; i++) issue(1'b0, waddr(words[i]), $urandom, 4'hF);
        drain();

        // Test 2: partial byte-masked write
        issue(1'b0, waddr(1), 32'h11223344, 4'hF);
        issue(1'b0, waddr(1), 32'hAABBCCDD, 4'b0101);
        issue(1'b1, waddr(1), 32'h0, 4'h0);
        drain();
        check("t2_rdata", last_rdata, 32'h11BB33DD);

        // Test 3: range and alignment errors, memory untouched
        issue(1'b0, waddr(DEPTH-1), 32'hCAFEF00D, 4'hF);
        issue(1'b0, waddr(0), 32'h01020304, 4'hF);
        issue(1'b1, BASE + 32'(DEPTH * 4), 32'h0, 4'h0);
        drain();
        check("t3_oor_err", last_err, 1'b1);
        issue(1'b1, BASE + 32'h2, 32'h0, 4'h0);
        drain();
        check("t3_mis_err", last_err, 1'b1);
        issue(1'b0, BASE - 32'h4, 32'hFFFFFFFF, 4'hF);
        drain();
        check("t3_below_err", last_err, 1'b1);
        issue(1'b1, waddr(DEPTH-1), 32'h0, 4'h0);
        drain();
        check("t3_top_kept", last_rdata, 32'hCAFEF00D);
        issue(1'b1, waddr(0), 32'h0, 4'h0);
        drain();
        check("t3_w0_kept", last_rdata, 32'h01020304);

        // Test 4: back-pressure with three queued reads
        icb_rsp_ready = 1'b0;
        accepted = 0; first_rsp = -1; third_acc = -1;
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = waddr(words[0]);
        for (int k = 0; k < 40 && (accepted < 3 || exp_q.size() != 0); k++) begin
            if (k == 6) icb_rsp_ready = 1'b1;
            cycle();
            if (last_rsp_hsk && first_rsp < 0) first_rsp = cyc;
            if (last_cmd_hsk) begin
                accepted++;
                if (accepted == 3) begin
                    third_acc = cyc;
                    icb_cmd_valid = 1'b0;
                end else begin
                    icb_cmd_addr = waddr(words[accepted]);
                end
            end
            if (k == 4) begin
                check("t4_full_ready", icb_cmd_ready, 1'b0);
                check("t4_accepted", accepted, 2);
            end
        end
        check("t4_third_lat", third_acc - first_rsp, 1);

        // Test 5: streaming, one accept every cycle
        icb_rsp_ready = 1'b1;
        icb_cmd_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rand_cmd();
            cycle();
            check("t5_stream_hsk", last_cmd_hsk, 1'b1);
            check("t5_outstanding", exp_q.size(), 1);
        end
        icb_cmd_valid = 1'b0;
        drain();

        // Random phase with random valid/ready
        rand_cmd();
        for (int k = 0; k < 300; k++) begin
            icb_rsp_ready = ($urandom_range(0, 3) != 0);
            if (!icb_cmd_valid) icb_cmd_valid = ($urandom_range(0, 9) < 7);
            cycle();
            if (last_cmd_hsk) begin
                rand_cmd();
                icb_cmd_valid = ($urandom_range(0, 9) < 7);
            end
        end
        icb_cmd_valid = 1'b0;
        drain();

        // Test 6: reset with two responses queued
        issue(1'b0, waddr(4), 32'h5A5A1234, 4'hF);
        drain();
        icb_rsp_ready = 1'b0;
        issue(1'b1, waddr(4), 32'h0, 4'h0);
        issue(1'b1, waddr(0), 32'h0, 4'h0);
        check("t6_queued", icb_rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", icb_rsp_valid, 1'b0);
        check("t6_rst_ready", icb_cmd_ready, 1'b1);
        check("t6_rst_rdata", icb_rsp_rdata, 32'h0);
        exp_q.delete();
        cycle();
        cycle();
        rst_n = 1'b1;
        icb_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        issue(1'b1, waddr(4), 32'h0, 4'h0);
        drain();
        check("t6_mem_kept", last_rdata, 32'h5A5A1234);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
